// File: rtl/snn_readout_pkg.sv
// Shared types and default sizing for the spiking-network output readout.
package snn_readout_pkg;

  localparam int unsigned DefNeurons    = 8;
  localparam int unsigned DefCountBits  = 8;
  localparam int unsigned DefWindowBits = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StScan  = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] q_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] q_q, q_d;

  // Clear has priority over increment; increment is dropped once saturated.
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != '1)) begin
      q_d = q_q + One;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/snn_spike_readout.sv
// Output-layer readout: counts spikes per neuron over a window of execute steps, then
// walks the counters serially to find the argmax class, its count and a tie flag.
module snn_spike_readout
  import snn_readout_pkg::*;
#(
  parameter int unsigned Neurons    = DefNeurons,
  parameter int unsigned CountBits  = DefCountBits,
  parameter int unsigned WindowBits = DefWindowBits,
  localparam int unsigned IdxBits   = (Neurons > 1) ? $clog2(Neurons) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic [Neurons-1:0]           spikes_i,
  input  logic [WindowBits-1:0]        window_len_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [IdxBits-1:0]           result_class_o,
  output logic [CountBits-1:0]         result_count_o,
  output logic                         result_tie_o,
  output logic [Neurons*CountBits-1:0] counts_flat_o
);

  localparam logic [WindowBits-1:0] StepOne = WindowBits'(1);
  localparam logic [IdxBits-1:0]    IdxOne  = IdxBits'(1);
  localparam logic [IdxBits-1:0]    IdxLast = IdxBits'(Neurons - 1);

  state_e                state_q, state_d;
  logic [WindowBits-1:0] step_q, step_d;
  logic [WindowBits-1:0] len_q, len_d;
  logic [IdxBits-1:0]    idx_q, idx_d;
  logic [CountBits-1:0]  best_q, best_d;
  logic [IdxBits-1:0]    class_q, class_d;
  logic                  tie_q, tie_d;

  logic [CountBits-1:0]  counts [Neurons];
  logic                  clear_cnt;
  logic                  acc_step;
  logic [CountBits-1:0]  cur_count;

  assign clear_cnt = (state_q == StIdle) && start_i;
  assign acc_step  = (state_q == StAccum) && enable_i;

  for (genvar g = 0; g < Neurons; g++) begin : gen_cnt
    sat_counter #(
      .Width(CountBits)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear_i(clear_cnt),
      .inc_i  (acc_step && spikes_i[g]),
      .q_o    (counts[g])
    );
    assign counts_flat_o[g*CountBits +: CountBits] = counts[g];
  end

  // Single shared comparator input for the serial argmax.
  assign cur_count = counts[idx_q];

  // Next-state logic: window control, step counting and the serial argmax scan.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    idx_d   = idx_q;
    best_d  = best_q;
    class_d = class_q;
    tie_d   = tie_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = window_len_i;
          step_d  = '0;
          idx_d   = '0;
          // An empty window skips accumulation and scans the freshly cleared counters.
          state_d = (window_len_i == '0) ? StScan : StAccum;
        end
      end
      StAccum: begin
        if (enable_i) begin
          step_d = step_q + StepOne;
          if ((step_q + StepOne) == len_q) begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (idx_q == '0) begin
          best_d  = cur_count;
          class_d = '0;
          tie_d   = 1'b0;
        end else if (cur_count > best_q) begin
          best_d  = cur_count;
          class_d = idx_q;
          tie_d   = 1'b0;
        end else if (cur_count == best_q) begin
          // Keep the lower index, just flag that the max is shared.
          tie_d = 1'b1;
        end
        idx_d = idx_q + IdxOne;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      class_q <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      class_q <= class_d;
      tie_q   <= tie_d;
    end
  end

  assign busy_o         = (state_q == StAccum) || (state_q == StScan);
  assign result_valid_o = (state_q == StDone);
  assign result_class_o = class_q;
  assign result_count_o = best_q;
  assign result_tie_o   = tie_q;

endmodule
